// File: rtl/dmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_if
//   Core-side LD/ST bus of the data-memory controller. Signal suffixes are
//   written from the controller's point of view (_i into dmem_ctrl, _o out).
//
//   Request  : valid_i, wen_i, byte_not_word_i, addr_i[31:0], write_data_i[31:0]
//              yumi_o   -> request accepted this cycle
//   Response : valid_o, read_data_o[31:0], err_o
//              yumi_i   -> response consumed this cycle
//   Status   : busy_o   -> controller not idle
//
//   modport master : the core (drives requests, consumes responses)
//   modport slave  : dmem_ctrl
// ---------------------------------------------------------------------------
interface dmem_ctrl_if;
    logic        valid_i;
    logic        wen_i;
    logic        byte_not_word_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic        yumi_o;
    logic        valid_o;
    logic [31:0] read_data_o;
    logic        yumi_i;
    logic        busy_o;
    logic        err_o;

    modport master (
        output valid_i, wen_i, byte_not_word_i, addr_i, write_data_i, yumi_i,
        input  yumi_o, valid_o, read_data_o, busy_o, err_o
    );

    modport slave (
        input  valid_i, wen_i, byte_not_word_i, addr_i, write_data_i, yumi_i,
        output yumi_o, valid_o, read_data_o, busy_o, err_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory controller behind the core's LD/ST port. One request in
//   flight: accept (IDLE) -> fixed latency (ACCESS) -> hold response (RESP).
//   Word or little-endian byte access on an internal 2**ADDR_WIDTH_P x 32
//   array. Byte loads are zero-extended; store responses return 0.
//
//   Parameters
//     ADDR_WIDTH_P : word-address bits (array depth 2**ADDR_WIDTH_P)
//     LATENCY_P    : cycles spent in ACCESS, 1..15
//
//   Ports
//     clk     : clock, all state on posedge
//     n_reset : asynchronous active-low reset
//     bus     : dmem_ctrl_if.slave (request/response handshake, status)
//
//   Optional feature (macro DMEM_ERR_EN)
//     Defined   : misaligned word accesses and addresses beyond the array
//                 raise err_o during RESP, with no write and read data 0.
//     Undefined : no checks; upper address bits wrap, word ops ignore
//                 addr[1:0]; err_o is always 0.
// ---------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_WIDTH_P = 10,
    parameter int LATENCY_P    = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    dmem_ctrl_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH_P;

    generate
        if (LATENCY_P < 1 || LATENCY_P > 15) begin : g_bad_latency
            $error("dmem_ctrl: LATENCY_P must be in 1..15");
        end
        if (ADDR_WIDTH_P < 1 || ADDR_WIDTH_P > 29) begin : g_bad_aw
            $error("dmem_ctrl: ADDR_WIDTH_P must be in 1..29");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        yumi;

    logic [31:0]             mem [DEPTH];
    logic [ADDR_WIDTH_P-1:0] idx;
    logic [1:0]              lane;
    logic [31:0]             rd_word;
    logic [7:0]              rd_byte;
    logic                    commit;
    logic                    addr_err;
    logic                    mem_we;

    assign idx     = addr_q[ADDR_WIDTH_P+1:2];
    assign lane    = addr_q[1:0];
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];

    // The access happens on the last ACCESS cycle.
    assign commit  = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef DMEM_ERR_EN
    assign addr_err = (!byte_q && lane != 2'd0) ||
                      ((addr_q >> (ADDR_WIDTH_P + 2)) != 32'd0);
`else
    // Upper address bits wrap silently in this build.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:ADDR_WIDTH_P+2];
    assign addr_err       = 1'b0;
`endif

    // An erroring store must leave the array untouched. Reset forces
    // state_q to IDLE asynchronously, so an aborted store never commits.
    assign mem_we = commit && wen_q && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        yumi    = 1'b0;
        unique case (state_q)
            IDLE: begin
                yumi = bus.valid_i;
                if (bus.valid_i) begin
                    wen_d   = bus.wen_i;
                    byte_d  = bus.byte_not_word_i;
                    addr_d  = bus.addr_i;
                    wdata_d = bus.write_data_i;
                    cnt_d   = 4'(LATENCY_P - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d = addr_err;
                    if (wen_q || addr_err) rdata_d = 32'd0;
                    else if (byte_q)       rdata_d = {24'd0, rd_byte};
                    else                   rdata_d = rd_word;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.yumi_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (byte_q) mem[idx][{lane, 3'b000} +: 8] <= wdata_q[7:0];
            else        mem[idx]                      <= wdata_q;
        end
    end

    assign bus.yumi_o      = yumi;
    assign bus.valid_o     = (state_q == RESP);
    assign bus.read_data_o = rdata_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//   Two controllers (LATENCY_P = 1 and 4) share clock and reset; sel_r picks
//   which one the driver talks to. Expected data comes from a flat word-array
//   model updated with the little-endian byte/word rules; expected latency is
//   1 + LATENCY_P cycles from acceptance. Compile with +define+DMEM_ERR_EN to
//   exercise the error build.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

    logic        clk;
    logic        n_reset;
    logic        v, wen, byt, yi, sel_r;
    logic [31:0] addr, wd;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [2][1024];

    dmem_ctrl_if bus1 ();
    dmem_ctrl_if bus4 ();

    assign bus1.valid_i         = v && !sel_r;
    assign bus1.wen_i           = wen;
    assign bus1.byte_not_word_i = byt;
    assign bus1.addr_i          = addr;
    assign bus1.write_data_i    = wd;
    assign bus1.yumi_i          = yi && !sel_r;

    assign bus4.valid_i         = v && sel_r;
    assign bus4.wen_i           = wen;
    assign bus4.byte_not_word_i = byt;
    assign bus4.addr_i          = addr;
    assign bus4.write_data_i    = wd;
    assign bus4.yumi_i          = yi && sel_r;

    logic        yumi, vo, busy, errs;
    logic [31:0] rdat;
    assign yumi = sel_r ? bus4.yumi_o      : bus1.yumi_o;
    assign vo   = sel_r ? bus4.valid_o     : bus1.valid_o;
    assign busy = sel_r ? bus4.busy_o      : bus1.busy_o;
    assign errs = sel_r ? bus4.err_o       : bus1.err_o;
    assign rdat = sel_r ? bus4.read_data_o : bus1.read_data_o;

    dmem_ctrl #(.ADDR_WIDTH_P(10), .LATENCY_P(1)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .bus(bus1)
    );
    dmem_ctrl #(.ADDR_WIDTH_P(10), .LATENCY_P(4)) u_dut4 (
        .clk(clk), .n_reset(n_reset), .bus(bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the selected DUT idle. With noise set, valid_i
    // stays high through ACCESS/RESP and yumi_i toggles during ACCESS; the
    // caller must then issue the next request immediately.
    task automatic xact(input bit s, input bit w, input bit b,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold, input bit noise,
                        output logic [31:0] rd, output logic re);
        int          lat;
        int          exp_lat;
        logic [9:0]  idx;
        logic [1:0]  ln;
        logic [31:0] word, e_rd;
        logic        e_err;
        idx     = a[11:2];
        ln      = a[1:0];
        exp_lat = s ? 5 : 2;
`ifdef DMEM_ERR_EN
        e_err = (!b && ln != 2'd0) || (a[31:12] != 20'd0);
`else
        e_err = 1'b0;
`endif
        word = mdl[s][idx];
        e_rd = 32'd0;
        if (!e_err) begin
            if (w) begin
                if (b) word[8*ln +: 8] = d[7:0];
                else   word = d;
                mdl[s][idx] = word;
            end else begin
                e_rd = b ? ((word >> (8*ln)) & 32'hFF) : word;
            end
        end

        sel_r = s; v = 1'b1; wen = w; byt = b; addr = a; wd = d; yi = 1'b0;
        #1 chk("accept", yumi, 1);
        @(negedge clk);
        v   = noise;
        lat = 1;
        while (!vo && lat < 40) begin
            #1;
            chk("busy_access", busy, 1);
            if (noise) chk("no_yumi_access", yumi, 0);
            yi = noise ? 1'($urandom % 2) : 1'b0;
            @(negedge clk);
            lat++;
        end
        yi = 1'b0;
        chk("latency", lat, exp_lat);
        chk("rdata", rdat, e_rd);
        chk("err", errs, e_err);
        rd = rdat;
        re = errs;
        for (int h = 0; h < hold; h++) begin
            #1;
            if (noise) chk("no_yumi_resp", yumi, 0);
            @(negedge clk);
            chk("hold_valid", vo, 1);
            chk("hold_rdata", rdat, rd);
            chk("hold_err", errs, re);
        end
        yi = 1'b1;
        #1;
        if (noise) chk("no_yumi_consume", yumi, 0);
        @(negedge clk);
        yi = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", vo, 0);
        chk("idle_err", errs, 0);
        if (noise) begin
            #1 chk("accept_after_resp", yumi, 1);
        end else begin
            v = 1'b0;
        end
    endtask

    logic [31:0] rd, old0;
    logic        re;

    initial begin
        v = 0; wen = 0; byt = 0; yi = 0; sel_r = 0; addr = 0; wd = 0;
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel_r = 1'(s);
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_valid", vo, 0);
            chk("rst_rdata", rdat, 0);
            chk("rst_err", errs, 0);
            chk("rst_yumi", yumi, 0);
        end
        sel_r   = 1'b0;
        n_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) xact(0, 1, 0, 32'(i * 4), $urandom, 0, 0, rd, re);
        for (int i = 0; i < 4; i++)  xact(1, 1, 0, 32'(i * 4), $urandom, 0, 0, rd, re);

        // SW then LW, minimum spacing
        xact(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, rd, re);
        xact(0, 0, 0, 32'h10, 32'h0, 0, 0, rd, re);
        chk("t1_lw", rd, 32'hDEADBEEF);

        // byte store touches only its lane
        xact(0, 1, 1, 32'h12, 32'hAAAAAA55, 0, 0, rd, re);
        xact(0, 0, 1, 32'h12, 32'h0, 0, 0, rd, re);
        chk("t2_lb", rd, 32'h00000055);
        xact(0, 0, 0, 32'h10, 32'h0, 0, 0, rd, re);
        chk("t2_lw", rd, 32'hDE55BEEF);

        // valid_i held during ACCESS/RESP, then accepted once back in IDLE
        xact(0, 0, 0, 32'h10, 32'h0, 1, 1, rd, re);
        xact(0, 0, 1, 32'h13, 32'h0, 0, 0, rd, re);
        chk("t4_lb3", rd, 32'h000000DE);

        // long latency with a stalled response
        xact(1, 1, 0, 32'h8, 32'hCAFEF00D, 0, 0, rd, re);
        xact(1, 0, 0, 32'h8, 32'h0, 3, 0, rd, re);
        chk("t3_lw", rd, 32'hCAFEF00D);

        // reset mid-ACCESS aborts the store
        sel_r = 1'b0; v = 1'b1; wen = 1'b1; byt = 1'b0; addr = 32'h20; wd = 32'h1234;
        #1 chk("t5_accept", yumi, 1);
        @(negedge clk);
        v = 1'b0;
        chk("t5_in_access", busy, 1);
        n_reset = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", vo, 0);
        chk("t5_rst_rdata", rdat, 0);
        chk("t5_rst_err", errs, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        xact(0, 0, 0, 32'h20, 32'h0, 0, 0, rd, re);
        chk("t5_not_written", (rd == 32'h1234) && (mdl[0][8] != 32'h1234), 0);

        // out-of-range and misaligned addresses
        xact(0, 0, 0, 32'h0, 32'h0, 0, 0, old0, re);
`ifdef DMEM_ERR_EN
        xact(0, 0, 0, 32'h11, 32'h0, 0, 0, rd, re);
        chk("t6_mis_err", re, 1);
        chk("t6_mis_rd", rd, 0);
        xact(0, 1, 0, 32'h1000, 32'h0BADF00D, 0, 0, rd, re);
        chk("t6_oob_err", re, 1);
        xact(0, 0, 0, 32'h0, 32'h0, 0, 0, rd, re);
        chk("t6_word0_kept", rd, old0);
`else
        xact(0, 1, 0, 32'h1000, 32'h0BADF00D, 0, 0, rd, re);
        chk("t6_wrap_err", re, 0);
        xact(0, 0, 0, 32'h0, 32'h0, 0, 0, rd, re);
        chk("t6_wrap_word0", rd, 32'h0BADF00D);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0]  ln;
            logic        w, b, nz;
            w  = 1'($urandom % 2);
            b  = 1'($urandom % 2);
            ln = (b || ($urandom % 4 == 0)) ? 2'($urandom) : 2'd0;
            a  = {(($urandom % 4) == 0) ? 20'($urandom) : 20'd0,
                  6'd0, 4'($urandom), ln};
            nz = (i < 59) && (($urandom % 4) == 0);
            xact(0, w, b, a, $urandom, int'($urandom % 3), nz, rd, re);
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = {30'($urandom % 4), 2'($urandom)};
            xact(1, 1'($urandom % 2), 1'($urandom % 2), a, $urandom,
                 int'($urandom % 3), 0, rd, re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
